board_cursor_controller: RTL

//  Producer side of the display_interface cursor/selection inputs. Turns five raw

---
 rtl/chess_pkg.sv | 33 +++
 rtl/board_cursor_controller_if.sv | 24 ++
 rtl/board_cursor_controller_button_debouncer.sv | 53 +++++
 rtl/board_cursor_controller.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared chess encodings, square addressing and cursor-controller FSM states.
package chess_pkg;

  localparam int unsigned SQ_ADDR_W = 6;

  // Piece codes held in bits [2:0] of each 4-bit board square
  localparam logic [2:0] PIECE_NONE   = 3'd0;
  localparam logic [2:0] PIECE_PAWN   = 3'd1;
  localparam logic [2:0] PIECE_KNIGHT = 3'd2;
  localparam logic [2:0] PIECE_BISHOP = 3'd3;
  localparam logic [2:0] PIECE_ROOK   = 3'd4;
  localparam logic [2:0] PIECE_QUEEN  = 3'd5;
  localparam logic [2:0] PIECE_KING   = 3'd6;

  // Colour held in bit [3] of each square; also the encoding of TURN
  localparam logic COLOR_WHITE = 1'b0;
  localparam logic COLOR_BLACK = 1'b1;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    SELECTED  = 2'b01,
    MOVE_PEND = 2'b10
  } ctrl_state_e;

  // Pack {row,col}; row 0 is the top of the screen
  function automatic logic [SQ_ADDR_W-1:0] sq_addr(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  // Row 6, column 4: the white king's pawn as seen from the player
  localparam logic [SQ_ADDR_W-1:0] CURSOR_RESET = sq_addr(3'd6, 3'd4);

endpackage

// File: rtl/board_cursor_controller_if.sv
// Move request handshake from the cursor controller to the game logic.
interface board_cursor_controller_if;
  import chess_pkg::*;

  logic                 move_valid;
  logic                 move_ready;
  logic [SQ_ADDR_W-1:0] move_from;
  logic [SQ_ADDR_W-1:0] move_to;

  modport master (
    output move_valid,
    output move_from,
    output move_to,
    input  move_ready
  );

  modport slave (
    input  move_valid,
    input  move_from,
    input  move_to,
    output move_ready
  );

endinterface

// File: rtl/board_cursor_controller_button_debouncer.sv
// Pushbutton conditioner: 2-FF synchronizer, stability counter and a one-cycle
// registered pulse on each accepted press (release produces no pulse).
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronized level disagrees with the accepted one
  always_comb begin
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync2_q;
      cnt_d   = '0;
      press_d = sync2_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Synchronizer and debounce state; reset to the released level
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/board_cursor_controller.sv
// Board cursor / selection controller: debounced buttons drive a cursor, a piece
// selection and a from/to move request on a valid/ready handshake.
// Optional feature: define CURSOR_WRAP_EN to make the cursor wrap at board edges
// (otherwise it saturates).
module board_cursor_controller
  import chess_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       BTN_UP,
  input  logic                       BTN_DOWN,
  input  logic                       BTN_LEFT,
  input  logic                       BTN_RIGHT,
  input  logic                       BTN_CENTER,
  input  logic [255:0]               BOARD,
  input  logic                       TURN,
  output logic [SQ_ADDR_W-1:0]       CURSOR_ADDR,
  output logic [SQ_ADDR_W-1:0]       SELECT_ADDR,
  output logic                       SELECT_EN,
  board_cursor_controller_if.master  move_if
);

  // Button index order: up, down, left, right, center
  logic [4:0] btn_raw, press;
  assign btn_raw = {BTN_CENTER, BTN_RIGHT, BTN_LEFT, BTN_DOWN, BTN_UP};

  for (genvar i = 0; i < 5; i++) begin : g_db
    button_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .clk_i  (CLK),
      .rst_i  (RESET),
      .btn_i  (btn_raw[i]),
      .press_o(press[i])
    );
  end

  ctrl_state_e          state_q, state_d;
  logic [SQ_ADDR_W-1:0] cursor_q, cursor_d, cursor_nxt;
  logic [SQ_ADDR_W-1:0] sel_q, sel_d, from_q, from_d, to_q, to_d;
  logic                 sel_en_q, sel_en_d, valid_q, valid_d;
  logic [3:0]           square;
  logic                 own_piece;
  logic [2:0]           row, col;

  assign square    = BOARD[{cursor_q, 2'b00} +: 4];
  assign own_piece = (square[2:0] != PIECE_NONE) && (square[3] == TURN);
  assign row       = cursor_q[5:3];
  assign col       = cursor_q[2:0];

  // Prioritised cursor step (UP > DOWN > LEFT > RIGHT) with edge handling
  always_comb begin
    cursor_nxt = cursor_q;
`ifdef CURSOR_WRAP_EN
    if      (press[0]) cursor_nxt = sq_addr(row - 3'd1, col);
    else if (press[1]) cursor_nxt = sq_addr(row + 3'd1, col);
    else if (press[2]) cursor_nxt = sq_addr(row, col - 3'd1);
    else if (press[3]) cursor_nxt = sq_addr(row, col + 3'd1);
`else
    if (press[0]) begin
      if (row != 3'd0) cursor_nxt = sq_addr(row - 3'd1, col);
    end else if (press[1]) begin
      if (row != 3'd7) cursor_nxt = sq_addr(row + 3'd1, col);
    end else if (press[2]) begin
      if (col != 3'd0) cursor_nxt = sq_addr(row, col - 3'd1);
    end else if (press[3]) begin
      if (col != 3'd7) cursor_nxt = sq_addr(row, col + 3'd1);
    end
`endif
  end

  // Selection / move-request FSM; CENTER overrides any same-cycle direction
  always_comb begin
    state_d  = state_q;
    cursor_d = cursor_q;
    sel_d    = sel_q;
    sel_en_d = sel_en_q;
    valid_d  = valid_q;
    from_d   = from_q;
    to_d     = to_q;
    unique case (state_q)
      IDLE: begin
        if (press[4]) begin
          if (own_piece) begin
            sel_d    = cursor_q;
            sel_en_d = 1'b1;
            state_d  = SELECTED;
          end
        end else begin
          cursor_d = cursor_nxt;
        end
      end
      SELECTED: begin
        if (press[4]) begin
          if (cursor_q == sel_q) begin
            sel_en_d = 1'b0;
            state_d  = IDLE;
          end else if (own_piece) begin
            sel_d = cursor_q;
          end else begin
            from_d  = sel_q;
            to_d    = cursor_q;
            valid_d = 1'b1;
            state_d = MOVE_PEND;
          end
        end else begin
          cursor_d = cursor_nxt;
        end
      end
      MOVE_PEND: begin
        if (valid_q && move_if.move_ready) begin
          valid_d  = 1'b0;
          sel_en_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        valid_d  = 1'b0;
        sel_en_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // Registered outputs and FSM state
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      cursor_q <= CURSOR_RESET;
      sel_q    <= '0;
      sel_en_q <= 1'b0;
      valid_q  <= 1'b0;
      from_q   <= '0;
      to_q     <= '0;
    end else begin
      state_q  <= state_d;
      cursor_q <= cursor_d;
      sel_q    <= sel_d;
      sel_en_q <= sel_en_d;
      valid_q  <= valid_d;
      from_q   <= from_d;
      to_q     <= to_d;
    end
  end

  assign CURSOR_ADDR        = cursor_q;
  assign SELECT_ADDR        = sel_q;
  assign SELECT_EN          = sel_en_q;
  assign move_if.move_valid = valid_q;
  assign move_if.move_from  = from_q;
  assign move_if.move_to    = to_q;

endmodule
